usb_audio_pcm_bridge: RTL and testbench
=======================================

Name: usb_audio_pcm_bridge

Overview:
Parametrised PCM bridge between the USB full-speed core's isochronous byte streams (EP01 OUT, EP82 IN) and a fixed-rate multi-channel audio interface. It is the generalised successor of the fixed 2ch/16-bit/512-deep audio glue logic. It adds configurable channel count, sample width, FIFO depth and packet size. It also adds OUT-path prefill/underrun recovery, sticky overflow/underrun flags and fill-level reporting. It sits between usbfs_core_top and the user audio datapath.

Parameters:
CHANNELS, 2, audio channels, 1..8
SAMPLE_BYTES, 2, bytes per sample, 2 or 3; SW = 8*SAMPLE_BYTES, FB = CHANNELS*SAMPLE_BYTES, FW = 8*FB
CLK_DIV, 1250, clk cycles per audio sample period, ≥ 4*FB
FIFO_AW, 9, FIFO address width; depth D = 2^FIFO_AW frames, each FIFO
PKT_SAMPLES, 48, frames per IN packet
PREFILL, 256, OUT FIFO level required to start or restart playback, 1..D
UNDERRUN_ZERO, 1, 1: output zeros on underrun; 0: hold last sample

Ports:
clk  in  1  system clock (60 MHz nominal)
rstn  in  1  asynchronous active-low reset
sof  in  1  start-of-frame pulse from USB core
out_data  in  8  EP01 byte
out_valid  in  1  EP01 byte strobe
in_data  out  8  EP82 byte
in_valid  out  1  EP82 data available
in_ready  in  1  EP82 byte accepted
audio_en  out  1  one-cycle sample strobe, every CLK_DIV cycles
audio_o  out  FW  host-to-device frame; channel k at [k*SW +: SW]
audio_i  in  FW  device-to-host frame, same packing; sampled when audio_en=1
playing  out  1  OUT path in RUN state
lvl_o  out  FIFO_AW+1  OUT FIFO occupancy
lvl_i  out  FIFO_AW+1  IN FIFO occupancy
clr_flags  in  1  synchronous clear of all sticky flags
ovf_o, unf_o, ovf_i, unf_i  out  1 each  sticky flags: OUT overflow, OUT underrun, IN overflow, IN underrun

Behaviour:
- Reset, asynchronous: counters, pointers, flags, audio_o, in_valid, audio_en and playing go to 0. The OUT state goes to PREFILL.
- Strobe: counter runs 0..CLK_DIV-1. audio_en=1 during the cycle after the counter reaches CLK_DIV-1. The first pulse comes CLK_DIV cycles after reset release.
- OUT assembly:
  - Byte counter runs 0..FB-1. Each out_valid byte shifts into the frame; the first byte is LSB of channel 0 (little-endian, channel-major).
  - The frame completes on byte FB-1. The push happens on the next edge if the OUT FIFO is not full. If full, the frame is dropped and ovf_o is set.
  - sof resets the byte counter and discards any partial frame. sof has priority over a simultaneous out_valid, which is discarded.
- OUT playback FSM:
  - PREFILL:
    - audio_en does not pop; audio_o is held.
    - Moves to RUN on the first audio_en with lvl_o ≥ PREFILL. That same edge pops and loads audio_o.
  - RUN:
    - audio_en with FIFO non-empty: pop, and load the head frame into audio_o on the same edge.
    - audio_en with FIFO empty: set unf_o, load audio_o with 0 (UNDERRUN_ZERO=1) or hold it, then return to PREFILL.
  - Eligibility: an entry pushed at edge t may be popped from edge t+2 onward. lvl_o and the empty test use eligible entries only.
- IN capture: on audio_en, audio_i is pushed into the IN FIFO. If the FIFO is full, the frame is dropped and ovf_i is set.
- IN packet:
  - sof resets byte index b (0..FB-1) and frame count f (0..PKT_SAMPLES-1), and sets in_valid=1. A packet in progress is truncated.
  - in_data = byte b of the IN FIFO head frame, same packing. It is combinational from the registered head.
  - in_ready with b=FB-1:
    - f advances.
    - If the FIFO is non-empty, pop; otherwise the head repeats and unf_i is set.
    - If f=PKT_SAMPLES-1, in_valid is cleared.
  - in_ready while in_valid=0 is ignored.
  - One packet is PKT_SAMPLES*FB bytes.
- FIFOs:
  - Pointers are FIFO_AW+1 bits, wrap-bit compare: full when the MSBs differ and the rest are equal.
  - A simultaneous push and pop at full is not possible by construction: the push is refused at full.
  - A simultaneous push and pop otherwise leaves the level unchanged.
  - Wrap-around past 2^FIFO_AW is transparent.
- Flags: each is set by its event and cleared only by reset or clr_flags. If clr_flags and a set event occur in the same cycle, set wins.
- Storage: memories are inferable as block RAM, with a single registered read port per FIFO.

Test Plan:
- Defaults: 4 bytes 0x34,0x12,0x78,0x56 on out_valid → after 256 such frames and the next audio_en, audio_o=0x56781234 and playing=1; lvl_o decrements by 1 per audio_en.
- CHANNELS=1, SAMPLE_BYTES=3, PREFILL=1: bytes 01,02,03 → audio_o=0x030201 at the first audio_en ≥2 cycles after the push; then no more data → next audio_en gives audio_o=0, unf_o=1, playing=0.
- Push D+1 frames with no audio_en → lvl_o=D, ovf_o=1; clr_flags pulse → ovf_o=0.
- sof after 3 of 4 bytes, then 4 fresh bytes → exactly one frame pushed, containing only the fresh bytes.
- audio_i=0x00020001 on 48 strobes, then sof, then in_ready held high → 192 bytes 01,00,02,00 repeating, then in_valid=0 with lvl_i=0 and unf_i=0.
- IN FIFO empty, sof, in_ready high → unf_i=1 and in_valid drops after 192 bytes; assert rstn mid-packet → in_valid=0, all levels 0 immediately.

Source files
------------

// File: rtl/usb_audio_pcm_bridge.sv
// rtl/usb_audio_pcm_bridge.sv - parametrised USB isochronous byte stream <-> PCM frame bridge
// Frame FIFO with registered read port; level/empty track only entries old enough for the read register.
module usb_audio_pcm_bridge_fifo #(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_lvl
);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;
  logic [AW:0]   r_wp;
  logic [AW:0]   r_wpe;
  logic [AW:0]   r_rp;
  logic [AW:0]   w_rp_nxt;

  assign w_rp_nxt = i_pop ? r_rp + PTR_ONE : r_rp;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_wdata;
    r_rdata <= r_mem[w_rp_nxt[AW-1:0]];
  end

  // r_wpe lags r_wp by one edge so a fresh entry is only visible once r_rdata can hold it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_wpe <= '0;
      r_rp  <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + PTR_ONE;
      r_wpe <= r_wp;
      r_rp  <= w_rp_nxt;
    end
  end

  assign o_rdata = r_rdata;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_empty = (r_wpe == r_rp);
  assign o_lvl   = r_wpe - r_rp;
endmodule

module usb_audio_pcm_bridge #(
  parameter int CHANNELS      = 2,
  parameter int SAMPLE_BYTES  = 2,
  parameter int CLK_DIV       = 1250,
  parameter int FIFO_AW       = 9,
  parameter int PKT_SAMPLES   = 48,
  parameter int PREFILL       = 256,
  parameter int UNDERRUN_ZERO = 1,
  localparam int FB = CHANNELS * SAMPLE_BYTES,
  localparam int FW = 8 * FB
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sof,
  input  logic [7:0]       out_data,
  input  logic             out_valid,
  output logic [7:0]       in_data,
  output logic             in_valid,
  input  logic             in_ready,
  output logic             audio_en,
  output logic [FW-1:0]    audio_o,
  input  logic [FW-1:0]    audio_i,
  output logic             playing,
  output logic [FIFO_AW:0] lvl_o,
  output logic [FIFO_AW:0] lvl_i,
  input  logic             clr_flags,
  output logic             ovf_o,
  output logic             unf_o,
  output logic             ovf_i,
  output logic             unf_i
);
  localparam int DIVW = $clog2(CLK_DIV);
  localparam int BW   = (FB > 1) ? $clog2(FB) : 1;
  localparam int PW   = (PKT_SAMPLES > 1) ? $clog2(PKT_SAMPLES) : 1;
  localparam logic [DIVW-1:0]  DIV_LAST    = DIVW'(CLK_DIV - 1);
  localparam logic [BW-1:0]    FB_LAST     = BW'(FB - 1);
  localparam logic [PW-1:0]    PKT_LAST    = PW'(PKT_SAMPLES - 1);
  localparam logic [FIFO_AW:0] PREFILL_LVL = (FIFO_AW+1)'(PREFILL);

  typedef enum logic {ST_PREFILL = 1'b0, ST_RUN = 1'b1} state_t;

  logic [DIVW-1:0]  r_div;
  logic             r_en;
  logic [BW-1:0]    r_obc;
  logic [FW-1:0]    r_asm;
  logic             r_opend;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [FW-1:0]    r_audio_o;
  logic [BW-1:0]    r_ib;
  logic [PW-1:0]    r_if;
  logic             r_in_valid;
  logic             r_ovf_o, r_unf_o, r_ovf_i, r_unf_i;

  logic             w_opush, w_opop, w_ounf, w_ofull, w_oempty;
  logic [FW-1:0]    w_ordata;
  logic [FIFO_AW:0] w_olvl;
  logic             w_ipush, w_ipop, w_ihs, w_ifull, w_iempty;
  logic [FW-1:0]    w_irdata;
  logic [FW-1:0]    w_ishift;
  logic [FIFO_AW:0] w_ilvl;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div <= '0;
      r_en  <= 1'b0;
    end else begin
      r_en  <= (r_div == DIV_LAST);
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIVW'(1);
    end
  end

  // Bytes shift in from the top, so after FB bytes the first one sits at the LSB
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_obc   <= '0;
      r_asm   <= '0;
      r_opend <= 1'b0;
    end else begin
      r_opend <= 1'b0;
      if (sof) begin
        r_obc <= '0;
      end else if (out_valid) begin
        r_asm <= {out_data, r_asm[FW-1:8]};
        if (r_obc == FB_LAST) begin
          r_obc   <= '0;
          r_opend <= 1'b1;
        end else begin
          r_obc <= r_obc + BW'(1);
        end
      end
    end
  end

  assign w_opush = r_opend && !w_ofull;

  usb_audio_pcm_bridge_fifo #(.DW(FW), .AW(FIFO_AW)) u_out_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_opush),
    .i_wdata (r_asm),
    .i_pop   (w_opop),
    .o_rdata (w_ordata),
    .o_full  (w_ofull),
    .o_empty (w_oempty),
    .o_lvl   (w_olvl)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_PREFILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PREFILL: if (r_en && (w_olvl >= PREFILL_LVL)) w_state_nxt = ST_RUN;
      ST_RUN:     if (r_en && w_oempty) w_state_nxt = ST_PREFILL;
      default:    w_state_nxt = ST_PREFILL;
    endcase
  end

  always_comb begin
    w_opop = 1'b0;
    w_ounf = 1'b0;
    case (r_state)
      ST_PREFILL: w_opop = r_en && (w_olvl >= PREFILL_LVL);
      ST_RUN: begin
        w_opop = r_en && !w_oempty;
        w_ounf = r_en && w_oempty;
      end
      default: begin
        w_opop = 1'b0;
        w_ounf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_audio_o <= '0;
    end else if (w_opop) begin
      r_audio_o <= w_ordata;
    end else if (w_ounf && (UNDERRUN_ZERO != 0)) begin
      r_audio_o <= '0;
    end
  end

  assign w_ipush = r_en && !w_ifull;

  usb_audio_pcm_bridge_fifo #(.DW(FW), .AW(FIFO_AW)) u_in_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_ipush),
    .i_wdata (audio_i),
    .i_pop   (w_ipop),
    .o_rdata (w_irdata),
    .o_full  (w_ifull),
    .o_empty (w_iempty),
    .o_lvl   (w_ilvl)
  );

  // Last byte of a frame accepted by the host: pop, or replay the head and flag underrun
  assign w_ihs  = in_ready && r_in_valid && !sof && (r_ib == FB_LAST);
  assign w_ipop = w_ihs && !w_iempty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ib       <= '0;
      r_if       <= '0;
      r_in_valid <= 1'b0;
    end else if (sof) begin
      r_ib       <= '0;
      r_if       <= '0;
      r_in_valid <= 1'b1;
    end else if (in_ready && r_in_valid) begin
      if (r_ib == FB_LAST) begin
        r_ib <= '0;
        if (r_if == PKT_LAST) begin
          r_if       <= '0;
          r_in_valid <= 1'b0;
        end else begin
          r_if <= r_if + PW'(1);
        end
      end else begin
        r_ib <= r_ib + BW'(1);
      end
    end
  end

  assign w_ishift = w_irdata >> {r_ib, 3'b000};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf_o <= 1'b0;
      r_unf_o <= 1'b0;
      r_ovf_i <= 1'b0;
      r_unf_i <= 1'b0;
    end else begin
      r_ovf_o <= (r_opend && w_ofull) ? 1'b1 : (clr_flags ? 1'b0 : r_ovf_o);
      r_unf_o <= w_ounf                ? 1'b1 : (clr_flags ? 1'b0 : r_unf_o);
      r_ovf_i <= (r_en && w_ifull)     ? 1'b1 : (clr_flags ? 1'b0 : r_ovf_i);
      r_unf_i <= (w_ihs && w_iempty)   ? 1'b1 : (clr_flags ? 1'b0 : r_unf_i);
    end
  end

  assign in_data  = w_ishift[7:0];
  assign in_valid = r_in_valid;
  assign audio_en = r_en;
  assign audio_o  = r_audio_o;
  assign playing  = (r_state == ST_RUN);
  assign lvl_o    = w_olvl;
  assign lvl_i    = w_ilvl;
  assign ovf_o    = r_ovf_o;
  assign unf_o    = r_unf_o;
  assign ovf_i    = r_ovf_i;
  assign unf_i    = r_unf_i;
endmodule

// File: tb/tb_usb_audio_pcm_bridge.sv
// tb/tb_usb_audio_pcm_bridge.sv - scoreboard bench for usb_audio_pcm_bridge (default-ish and 1ch/24-bit builds)
module tb_usb_audio_pcm_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rstn = 1'b0, a_sof = 1'b0, a_out_valid = 1'b0, a_in_ready = 1'b0, a_clr = 1'b0;
  logic [7:0]  a_out_data = '0, a_in_data;
  logic        a_in_valid, a_audio_en, a_playing, a_ovf_o, a_unf_o, a_ovf_i, a_unf_i;
  logic [31:0] a_audio_o, a_audio_i = 32'h00020001;
  logic [9:0]  a_lvl_o, a_lvl_i;

  logic        b_rstn = 1'b0, b_sof = 1'b0, b_out_valid = 1'b0, b_in_ready = 1'b0, b_clr = 1'b0;
  logic [7:0]  b_out_data = '0, b_in_data;
  logic        b_in_valid, b_audio_en, b_playing, b_ovf_o, b_unf_o, b_ovf_i, b_unf_i;
  logic [23:0] b_audio_o, b_audio_i = 24'hABCDEF;
  logic [3:0]  b_lvl_o, b_lvl_i;

  usb_audio_pcm_bridge #(.CLK_DIV(300)) u_a (
    .clk(clk), .rstn(a_rstn), .sof(a_sof), .out_data(a_out_data), .out_valid(a_out_valid),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready), .audio_en(a_audio_en),
    .audio_o(a_audio_o), .audio_i(a_audio_i), .playing(a_playing), .lvl_o(a_lvl_o), .lvl_i(a_lvl_i),
    .clr_flags(a_clr), .ovf_o(a_ovf_o), .unf_o(a_unf_o), .ovf_i(a_ovf_i), .unf_i(a_unf_i)
  );

  usb_audio_pcm_bridge #(.CHANNELS(1), .SAMPLE_BYTES(3), .CLK_DIV(1000), .FIFO_AW(3),
                         .PKT_SAMPLES(64), .PREFILL(1)) u_b (
    .clk(clk), .rstn(b_rstn), .sof(b_sof), .out_data(b_out_data), .out_valid(b_out_valid),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready), .audio_en(b_audio_en),
    .audio_o(b_audio_o), .audio_i(b_audio_i), .playing(b_playing), .lvl_o(b_lvl_o), .lvl_i(b_lvl_i),
    .clr_flags(b_clr), .ovf_o(b_ovf_o), .unf_o(b_unf_o), .ovf_i(b_ovf_i), .unf_i(b_unf_i)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] q_aout[$];
  logic [23:0] q_bout[$];
  logic [7:0]  q_ain[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_byte(input logic [7:0] d);
    a_out_data = d; a_out_valid = 1'b1;
    @(negedge clk);
    a_out_valid = 1'b0;
  endtask

  task automatic b_byte(input logic [7:0] d);
    b_out_data = d; b_out_valid = 1'b1;
    @(negedge clk);
    b_out_valid = 1'b0;
  endtask

  task automatic wait_a_str(input string tag);
    int n = 0;
    while (!a_audio_en && n < 400) begin @(negedge clk); n++; end
    if (!a_audio_en) check(tag, 0, 1);
  endtask

  task automatic wait_b_str(input string tag);
    int n = 0;
    while (!b_audio_en && n < 1100) begin @(negedge clk); n++; end
    if (!b_audio_en) check(tag, 0, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] exp_a;
    logic [23:0] exp_b;
    logic [7:0]  exp_byte;

    repeat (2) @(negedge clk);
    check("a_rst_state", {a_audio_en, a_playing, a_in_valid, a_ovf_o, a_unf_o, a_ovf_i, a_unf_i}, 0);
    check("a_rst_lvl", {a_lvl_o, a_lvl_i}, 0);
    check("a_rst_audio_o", a_audio_o, 0);
    check("b_rst_state", {b_audio_en, b_playing, b_in_valid, b_lvl_o, b_lvl_i}, 0);
    a_rstn = 1'b1; b_rstn = 1'b1;

    n = 0;
    do begin @(negedge clk); n++; end while (!a_audio_en && n < 1000);
    check("a_first_strobe", n, 300);

    // partial frame, then sof with a colliding byte: both must vanish
    a_byte(8'hAA); a_byte(8'hBB); a_byte(8'hCC);
    a_sof = 1'b1; a_out_data = 8'hDD; a_out_valid = 1'b1;
    @(negedge clk);
    a_sof = 1'b0; a_out_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'h34 + 8'(i); b1 = 8'h12 + 8'(i); b2 = 8'h78 + 8'(i); b3 = 8'h56 + 8'(i);
      a_byte(b0); a_byte(b1); a_byte(b2); a_byte(b3);
      q_aout.push_back({b3, b2, b1, b0});
    end
    n = 0;
    while (a_lvl_o != 10'd256 && n < 20) begin @(negedge clk); n++; end
    check("a_prefill_lvl", a_lvl_o, 256);
    check("a_prefill_idle", a_playing, 0);
    for (int k = 0; k < 3; k++) begin
      wait_a_str("a_strobe_timeout");
      check("a_lvl_pre", a_lvl_o, 64'(256 - k));
      @(negedge clk);
      exp_a = (q_aout.size() > 0) ? q_aout.pop_front() : 32'hx;
      check("a_audio_o", a_audio_o, exp_a);
      if (k == 0) check("a_first_frame", a_audio_o, 32'h56781234);
      check("a_playing", a_playing, 1);
      check("a_lvl_post", a_lvl_o, 64'(255 - k));
    end

    // IN path: 48 captured frames, then one full packet
    a_rstn = 1'b0;
    @(negedge clk);
    check("a_rst_lvl_i", a_lvl_i, 0);
    a_rstn = 1'b1;
    q_ain.delete();
    n = 0;
    for (int c = 0; c < 20000 && n < 48; c++) begin
      @(negedge clk);
      if (a_audio_en) begin
        n++;
        for (int j = 0; j < 4; j++) q_ain.push_back(a_audio_i[j*8 +: 8]);
      end
    end
    check("a_in_strobes", n, 48);
    n = 0;
    while (a_lvl_i != 10'd48 && n < 20) begin @(negedge clk); n++; end
    check("a_lvl_i_full", a_lvl_i, 48);
    a_sof = 1'b1;
    @(negedge clk);
    a_sof = 1'b0; a_in_ready = 1'b1;
    n = 0;
    while (a_in_valid && n < 400) begin
      exp_byte = (q_ain.size() > 0) ? q_ain.pop_front() : 8'hx;
      check("a_in_data", a_in_data, exp_byte);
      n++;
      @(negedge clk);
    end
    a_in_ready = 1'b0;
    check("a_pkt_len", n, 192);
    check("a_pkt_end_valid", a_in_valid, 0);
    check("a_pkt_end_lvl_i", a_lvl_i, 0);
    check("a_pkt_end_unf_i", a_unf_i, 0);

    // B: IN packet with an empty FIFO
    b_rstn = 1'b0;
    @(negedge clk);
    b_rstn = 1'b1;
    b_sof = 1'b1;
    @(negedge clk);
    b_sof = 1'b0; b_in_ready = 1'b1;
    n = 0;
    while (b_in_valid && n < 300) begin @(negedge clk); n++; end
    b_in_ready = 1'b0;
    check("b_empty_pkt_len", n, 192);
    check("b_empty_unf_i", b_unf_i, 1);
    check("b_empty_valid", b_in_valid, 0);

    // B: single 24-bit frame, then underrun
    b_byte(8'h01); b_byte(8'h02); b_byte(8'h03);
    q_bout.push_back(24'h030201);
    n = 0;
    while (b_lvl_o != 4'd1 && n < 20) begin @(negedge clk); n++; end
    check("b_lvl_one", b_lvl_o, 1);
    wait_b_str("b_strobe_timeout");
    @(negedge clk);
    exp_b = (q_bout.size() > 0) ? q_bout.pop_front() : 24'hx;
    check("b_audio_o", b_audio_o, exp_b);
    check("b_playing", b_playing, 1);
    check("b_lvl_drained", b_lvl_o, 0);
    check("b_no_unf", b_unf_o, 0);
    wait_b_str("b_strobe_timeout");
    @(negedge clk);
    check("b_unf_zero", b_audio_o, 0);
    check("b_unf_o", b_unf_o, 1);
    check("b_unf_stop", b_playing, 0);

    // B: overflow with D+1 frames, then flag clear
    for (int i = 0; i < 9; i++) begin
      b_byte(8'h10 + 8'(i)); b_byte(8'h20 + 8'(i)); b_byte(8'h30 + 8'(i));
    end
    repeat (3) @(negedge clk);
    check("b_ovf_lvl", b_lvl_o, 8);
    check("b_ovf_o", b_ovf_o, 1);
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    check("b_clr_ovf_o", b_ovf_o, 0);
    check("b_clr_unf", {b_unf_o, b_unf_i}, 0);

    // B: reset mid-packet acts immediately
    b_sof = 1'b1;
    @(negedge clk);
    b_sof = 1'b0; b_in_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("b_mid_valid", b_in_valid, 1);
    b_rstn = 1'b0;
    #1;
    check("b_async_valid", b_in_valid, 0);
    check("b_async_lvl_o", b_lvl_o, 0);
    check("b_async_lvl_i", b_lvl_i, 0);
    b_in_ready = 1'b0;
    @(negedge clk);
    b_rstn = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
